// File: rtl/risc16_dbg_port.sv
// Debug responder for the RISC16 core: halts the CPU, performs one debug-bus access, returns the result.
// Optional sticky halt control register enabled by defining RISC16_DBG_STICKY_HALT_EN.
module risc16_dbg_port #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int HALT_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_space,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              cpu_halt,
    input  logic              cpu_halted,
    output logic              dbg_re,
    output logic              dbg_we,
    output logic [1:0]        dbg_space,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_wdata,
    input  logic [DATA_W-1:0] dbg_rdata
);

    // Handshakes: a request moves on req_valid & req_ready, a response on resp_valid & resp_ready;
    // the response fields stay stable until accepted.

    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HALT_WAIT = 3'd1,
        S_ACCESS    = 3'd2,
        S_RDWAIT    = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic              r_busy;
    logic [1:0]        r_space;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic              w_ctrl;
    logic              w_immediate;
    logic              w_imm_err;
    logic [DATA_W-1:0] w_imm_rdata;

    // r0 is hardwired zero, so its accesses never need the CPU stopped.
    assign w_ctrl      = (req_space == 2'd3);
    assign w_immediate = w_ctrl || (req_space == 2'd0 && req_addr[2:0] == 3'd0);

`ifdef RISC16_DBG_STICKY_HALT_EN
    logic r_halt_latch;
    assign w_imm_err   = 1'b0;
    assign w_imm_rdata = (w_ctrl && !req_write) ? {{(DATA_W-1){1'b0}}, r_halt_latch} : '0;
    assign cpu_halt    = r_busy | r_halt_latch;
`else
    assign w_imm_err   = w_ctrl;
    assign w_imm_rdata = '0;
    assign cpu_halt    = r_busy;
`endif

    assign dbg_space  = r_space;
    assign dbg_addr   = r_addr;
    assign dbg_wdata  = r_wdata;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        dbg_re     = 1'b0;
        dbg_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = w_immediate ? S_RESP : S_HALT_WAIT;
            end
            S_HALT_WAIT: begin
                if (cpu_halted)             w_next = S_ACCESS;
                else if (r_cnt == CNT_LAST) w_next = S_RESP;
            end
            S_ACCESS: begin
                dbg_we = r_write;
                dbg_re = !r_write;
                w_next = r_write ? S_RESP : S_RDWAIT;
            end
            S_RDWAIT: w_next = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
            r_space      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
`ifdef RISC16_DBG_STICKY_HALT_EN
            r_halt_latch <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write      <= req_write;
                        r_space      <= req_space;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_cnt        <= '0;
                        r_resp_rdata <= w_imm_rdata;
                        r_resp_err   <= w_imm_err;
                        r_busy       <= !w_immediate;
`ifdef RISC16_DBG_STICKY_HALT_EN
                        if (w_ctrl && req_write) r_halt_latch <= req_wdata[0];
`endif
                    end
                end
                S_HALT_WAIT: begin
                    if (!cpu_halted) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_LAST) r_resp_err <= 1'b1;
                    end
                end
                S_RDWAIT: r_resp_rdata <= dbg_rdata;
                S_RESP: begin
                    // Halt request is released on the same edge that consumes the response.
                    if (resp_ready) begin
                        r_busy       <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_dbg_port.sv
// Self-checking bench for risc16_dbg_port: table of host transactions plus stall/reset and halt-control sequences.
module tb_risc16_dbg_port;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
`ifdef RISC16_DBG_STICKY_HALT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_space;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              cpu_halt;
  logic              cpu_halted;
  logic              dbg_re;
  logic              dbg_we;
  logic [1:0]        dbg_space;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;

  int checks = 0;
  int failures = 0;

  risc16_dbg_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_space(req_space), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .cpu_halt(cpu_halt), .cpu_halted(cpu_halted),
    .dbg_re(dbg_re), .dbg_we(dbg_we), .dbg_space(dbg_space), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- CPU model ----------------
  // halt_mode: 0 = never acks, 1 = ack held high, 2 = ack after cpu_halt has been high for 2 cycles
  int halt_mode = 1;
  int hcnt = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  logic [1:0]        lw_space;
  logic [ADDR_W-1:0] lw_addr;
  logic [DATA_W-1:0] lw_wdata;
  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] imem [256];
  logic [DATA_W-1:0] dmem [256];

  assign cpu_halted = (halt_mode == 1) || (halt_mode == 2 && hcnt >= 2);

  always @(posedge clk) begin
    hcnt <= cpu_halt ? hcnt + 1 : 0;
    if (rst) begin
      rf[3]         <= 16'h1234;
      dmem[8'h20]   <= 16'hBEEF;
    end
    if (dbg_re) begin
      re_cnt <= re_cnt + 1;
      case (dbg_space)
        2'd0:    dbg_rdata <= rf[dbg_addr[2:0]];
        2'd1:    dbg_rdata <= imem[dbg_addr];
        default: dbg_rdata <= dmem[dbg_addr];
      endcase
    end
    if (dbg_we) begin
      we_cnt   <= we_cnt + 1;
      lw_space <= dbg_space;
      lw_addr  <= dbg_addr;
      lw_wdata <= dbg_wdata;
      case (dbg_space)
        2'd0:    rf[dbg_addr[2:0]] <= dbg_wdata;
        2'd1:    imem[dbg_addr] <= dbg_wdata;
        default: dmem[dbg_addr] <= dbg_wdata;
      endcase
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_rdata"}, resp_rdata, 0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_cpu_halt"}, cpu_halt, 0);
    check({tag, "_dbg_re"}, dbg_re, 0);
    check({tag, "_dbg_we"}, dbg_we, 0);
    check({tag, "_dbg_space"}, dbg_space, 0);
    check({tag, "_dbg_addr"}, dbg_addr, 0);
    check({tag, "_dbg_wdata"}, dbg_wdata, 0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; lat counts cycles from the accept cycle (0) to first resp_valid.
  task automatic do_req(input logic wr, input logic [1:0] sp, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] rd,
                        output logic er, output int lat, output logic halt_resp,
                        output logic halt_after);
    int guard;
    req_write = wr;
    req_space = sp;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    halt_resp = cpu_halt;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    halt_after = cpu_halt;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              wr;
    logic [1:0]        sp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                mode;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
    int                exp_lat;
    int                exp_re;
    int                exp_we;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    logic [DATA_W-1:0] rd;
    logic er, hr, ha;
    int lat, re0, we0;

    vecs[0]  = '{1'b0, 2'd0, 8'h03, 16'h0000, 2, 16'h1234, 1'b0, 6, 1, 0};
    vecs[1]  = '{1'b1, 2'd1, 8'h05, 16'hA5C3, 1, 16'h0000, 1'b0, 3, 0, 1};
    vecs[2]  = '{1'b0, 2'd1, 8'h05, 16'h0000, 1, 16'hA5C3, 1'b0, 4, 1, 0};
    vecs[3]  = '{1'b1, 2'd0, 8'h00, 16'hFFFF, 1, 16'h0000, 1'b0, 1, 0, 0};
    vecs[4]  = '{1'b0, 2'd0, 8'h00, 16'h0000, 1, 16'h0000, 1'b0, 1, 0, 0};
    vecs[5]  = '{1'b0, 2'd2, 8'h07, 16'h0000, 0, 16'h0000, 1'b1, 16, 0, 0};
    vecs[6]  = '{1'b1, 2'd2, 8'h10, 16'h3C5A, 1, 16'h0000, 1'b0, 3, 0, 1};
    vecs[7]  = '{1'b0, 2'd2, 8'h10, 16'h0000, 2, 16'h3C5A, 1'b0, 6, 1, 0};
    vecs[8]  = '{1'b1, 2'd0, 8'h09, 16'h5555, 1, 16'h0000, 1'b0, 3, 0, 1};
    vecs[9]  = '{1'b0, 2'd0, 8'h01, 16'h0000, 1, 16'h5555, 1'b0, 4, 1, 0};
    vecs[10] = '{1'b1, 2'd0, 8'h08, 16'h1234, 1, 16'h0000, 1'b0, 1, 0, 0};
    vecs[11] = '{1'b1, 2'd3, 8'h00, 16'h0000, 1, 16'h0000, !STICKY, 1, 0, 0};
    vecs[12] = '{1'b0, 2'd3, 8'h00, 16'h0000, 1, 16'h0000, !STICKY, 1, 0, 0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_space = 2'd0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < NV; i++) begin
      halt_mode = vecs[i].mode;
      re0 = re_cnt;
      we0 = we_cnt;
      do_req(vecs[i].wr, vecs[i].sp, vecs[i].addr, vecs[i].wdata, rd, er, lat, hr, ha);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), er, vecs[i].exp_err);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_re_count", i), re_cnt - re0, vecs[i].exp_re);
      check($sformatf("v%0d_we_count", i), we_cnt - we0, vecs[i].exp_we);
      check($sformatf("v%0d_halt_at_resp", i), hr, (vecs[i].exp_lat > 1));
      check($sformatf("v%0d_halt_after", i), ha, 0);
      if (vecs[i].exp_we == 1) begin
        check($sformatf("v%0d_we_space", i), lw_space, vecs[i].sp);
        check($sformatf("v%0d_we_addr", i), lw_addr, vecs[i].addr);
        check($sformatf("v%0d_we_wdata", i), lw_wdata, vecs[i].wdata);
      end
    end

    // Response stall: host holds resp_ready low while a second request waits, then reset hits.
    halt_mode = 1;
    req_write = 1'b0;
    req_space = 2'd2;
    req_addr  = 8'h20;
    req_wdata = '0;
    req_valid = 1'b1;
    check("stall_ready_before", req_ready, 1);
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 8'h21;
    req_wdata = 16'h1111;
    we0 = we_cnt;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("stall_latency", lat, 4);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("stall%0d_resp_valid", c), resp_valid, 1);
      check($sformatf("stall%0d_rdata", c), resp_rdata, 16'hBEEF);
      check($sformatf("stall%0d_err", c), resp_err, 0);
      check($sformatf("stall%0d_cpu_halt", c), cpu_halt, 1);
      check($sformatf("stall%0d_req_ready", c), req_ready, 0);
      @(negedge clk);
    end
    check("stall_second_req_not_run", we_cnt - we0, 0);
    rst = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);

`ifdef RISC16_DBG_STICKY_HALT_EN
    halt_mode = 1;
    do_req(1'b1, 2'd3, 8'h00, 16'h0001, rd, er, lat, hr, ha);
    check("sticky_set_err", er, 0);
    check("sticky_set_halt_after", ha, 1);
    do_req(1'b0, 2'd0, 8'h01, 16'h0000, rd, er, lat, hr, ha);
    check("sticky_r1_rdata", rd, 16'h5555);
    check("sticky_r1_halt_after", ha, 1);
    do_req(1'b0, 2'd3, 8'h00, 16'h0000, rd, er, lat, hr, ha);
    check("sticky_ctrl_read", rd, 16'h0001);
    do_req(1'b1, 2'd3, 8'h00, 16'h0000, rd, er, lat, hr, ha);
    check("sticky_clear_halt_after", ha, 0);
`else
    do_req(1'b1, 2'd3, 8'h00, 16'h0001, rd, er, lat, hr, ha);
    check("ctrl_write_err", er, 1);
    check("ctrl_write_halt_after", ha, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
